multicycle_controller: RTL

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

---
 rtl/multicycle_controller_pkg.sv | 113 +++++++++++
 rtl/multicycle_controller_if.sv | 39 +++
 rtl/multicycle_controller_condition_check.sv | 29 ++
 rtl/multicycle_controller.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/multicycle_controller_pkg.sv
// Shared types and encodings for the multicycle controller: state codes, ALU
// operations, datapath mux selects, condition codes and their evaluation.
package multicycle_pkg;

   typedef enum logic [3:0] {
      S_FETCH         = 4'd0,
      S_DECODE        = 4'd1,
      S_MEM_ADDRESS   = 4'd2,
      S_MEM_READ      = 4'd3,
      S_MEM_WRITEBACK = 4'd4,
      S_MEM_WRITE     = 4'd5,
      S_EXECUTE_REG   = 4'd6,
      S_EXECUTE_IMM   = 4'd7,
      S_ALU_WRITEBACK = 4'd8,
      S_BRANCH        = 4'd9
   } state_t;

   typedef enum logic [1:0] {
      ALU_ADD = 2'b00,
      ALU_SUB = 2'b01,
      ALU_AND = 2'b10,
      ALU_ORR = 2'b11
   } alu_ctl_t;

   typedef struct packed {
      logic     valid;
      alu_ctl_t ctl;
   } alu_decode_t;

   localparam logic [1:0] RES_ALU_OUT    = 2'b00;
   localparam logic [1:0] RES_READ_DATA  = 2'b01;
   localparam logic [1:0] RES_ALU_RESULT = 2'b10;

   localparam logic       SRCA_REG  = 1'b0;
   localparam logic       SRCA_PC   = 1'b1;
   localparam logic [1:0] SRCB_REG  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   localparam logic       ADDR_PC     = 1'b0;
   localparam logic       ADDR_RESULT = 1'b1;

   localparam logic [1:0] IMM_DP  = 2'b00;
   localparam logic [1:0] IMM_MEM = 2'b01;
   localparam logic [1:0] IMM_BR  = 2'b10;

   localparam logic [1:0] OP_DP  = 2'b00;
   localparam logic [1:0] OP_MEM = 2'b01;
   localparam logic [1:0] OP_BR  = 2'b10;

   localparam logic [3:0] FN_ADD = 4'b0100;
   localparam logic [3:0] FN_SUB = 4'b0010;
   localparam logic [3:0] FN_AND = 4'b0000;
   localparam logic [3:0] FN_ORR = 4'b1100;

   localparam logic [3:0] COND_EQ = 4'b0000;
   localparam logic [3:0] COND_NE = 4'b0001;
   localparam logic [3:0] COND_CS = 4'b0010;
   localparam logic [3:0] COND_CC = 4'b0011;
   localparam logic [3:0] COND_MI = 4'b0100;
   localparam logic [3:0] COND_PL = 4'b0101;
   localparam logic [3:0] COND_VS = 4'b0110;
   localparam logic [3:0] COND_VC = 4'b0111;
   localparam logic [3:0] COND_HI = 4'b1000;
   localparam logic [3:0] COND_LS = 4'b1001;
   localparam logic [3:0] COND_GE = 4'b1010;
   localparam logic [3:0] COND_LT = 4'b1011;
   localparam logic [3:0] COND_GT = 4'b1100;
   localparam logic [3:0] COND_LE = 4'b1101;
   localparam logic [3:0] COND_AL = 4'b1110;

   // Unsupported function codes fall back to ADD with valid cleared.
   function automatic alu_decode_t decode_alu(input logic [3:0] fn);
      alu_decode_t d;
      d.valid = 1'b1;
      case (fn)
         FN_ADD:  d.ctl = ALU_ADD;
         FN_SUB:  d.ctl = ALU_SUB;
         FN_AND:  d.ctl = ALU_AND;
         FN_ORR:  d.ctl = ALU_ORR;
         default: begin
            d.valid = 1'b0;
            d.ctl   = ALU_ADD;
         end
      endcase
      return d;
   endfunction

   // nzcv is {N,Z,C,V}; code 1111 never executes.
   function automatic logic cond_holds(input logic [3:0] cond, input logic [3:0] nzcv);
      logic n, z, c, v;
      {n, z, c, v} = nzcv;
      case (cond)
         COND_EQ: return z;
         COND_NE: return !z;
         COND_CS: return c;
         COND_CC: return !c;
         COND_MI: return n;
         COND_PL: return !n;
         COND_VS: return v;
         COND_VC: return !v;
         COND_HI: return c && !z;
         COND_LS: return !c || z;
         COND_GE: return n == v;
         COND_LT: return n != v;
         COND_GT: return !z && (n == v);
         COND_LE: return z || (n != v);
         COND_AL: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Instruction fields and status in, datapath control strobes and selects out.
// master is the datapath side, slave is the controller.
interface multicycle_controller_if;

   logic [3:0] condition;
   logic [1:0] operation;
   logic [5:0] function_field;
   logic [3:0] destination;
   logic [3:0] alu_flags;
   logic       memory_ready;

   logic       pc_write;
   logic       address_source;
   logic       instruction_register_write;
   logic       register_write;
   logic       memory_write;
   logic [1:0] result_source;
   logic       alu_source_a;
   logic [1:0] alu_source_b;
   logic [1:0] immediate_source;
   logic [1:0] register_source;
   logic [1:0] alu_control;
   logic [3:0] state;

   modport master (
      output condition, operation, function_field, destination, alu_flags, memory_ready,
      input  pc_write, address_source, instruction_register_write, register_write,
             memory_write, result_source, alu_source_a, alu_source_b,
             immediate_source, register_source, alu_control, state
   );

   modport slave (
      input  condition, operation, function_field, destination, alu_flags, memory_ready,
      output pc_write, address_source, instruction_register_write, register_write,
             memory_write, result_source, alu_source_a, alu_source_b,
             immediate_source, register_source, alu_control, state
   );

endinterface

// File: rtl/multicycle_controller_condition_check.sv
// NZCV flags register and condition evaluation; cond_ex_q is captured once per
// instruction as DECODE exits and held until the next DECODE.
module condition_check
   import multicycle_pkg::*;
(
   input  logic       clk,
   input  logic       reset_n,
   input  logic [3:0] condition,
   input  logic [3:0] alu_flags,
   input  logic       cond_latch,
   input  logic       flag_write_nz,
   input  logic       flag_write_cv,
   output logic       cond_ex_q
);

   logic [3:0] flags_reg;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         flags_reg <= 4'b0000;
         cond_ex_q <= 1'b0;
      end else begin
         if (flag_write_nz) flags_reg[3:2] <= alu_flags[3:2];
         if (flag_write_cv) flags_reg[1:0] <= alu_flags[1:0];
         if (cond_latch)    cond_ex_q      <= cond_holds(condition, flags_reg);
      end
   end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle ARM-subset main controller. Define CONDITIONAL_EXECUTION_EN to add
// the flags register and condition evaluation; otherwise every instruction executes.
module multicycle_controller
   import multicycle_pkg::*;
(
   input  logic               clk,
   input  logic               reset_n,
   multicycle_controller_if.slave bus
);

   state_t      state_reg, state_next;
   alu_decode_t dp;
   logic        cond_ex_q;
   logic        wr_ok;

   logic       pc_write_c, ir_write_c, reg_write_c, mem_write_c;
   logic       addr_src_c, src_a_c;
   logic [1:0] res_src_c, src_b_c, alu_ctl_c;

   assign dp = decode_alu(bus.function_field[4:1]);

`ifdef CONDITIONAL_EXECUTION_EN
   logic exec_exit, flag_nz, flag_cv;

   assign exec_exit = (state_reg == S_EXECUTE_REG) || (state_reg == S_EXECUTE_IMM);
   assign flag_nz   = exec_exit && bus.function_field[0] && dp.valid && cond_ex_q;
   assign flag_cv   = flag_nz && ((dp.ctl == ALU_ADD) || (dp.ctl == ALU_SUB));

   condition_check u_condition_check (
      .clk           (clk),
      .reset_n       (reset_n),
      .condition     (bus.condition),
      .alu_flags     (bus.alu_flags),
      .cond_latch    (state_reg == S_DECODE),
      .flag_write_nz (flag_nz),
      .flag_write_cv (flag_cv),
      .cond_ex_q     (cond_ex_q)
   );
`else
   logic unused_cond_inputs;
   assign unused_cond_inputs = ^{bus.condition, bus.alu_flags};
   assign cond_ex_q = 1'b1;
`endif

   always_ff @(posedge clk) begin
      if (!reset_n) state_reg <= S_FETCH;
      else          state_reg <= state_next;
   end

   // Reset gates every strobe combinationally so a mid-instruction reset
   // cannot commit a write in the cycle it is asserted.
   assign wr_ok = cond_ex_q && reset_n;

   always_comb begin
      state_next  = S_FETCH;
      pc_write_c  = 1'b0;
      ir_write_c  = 1'b0;
      reg_write_c = 1'b0;
      mem_write_c = 1'b0;
      addr_src_c  = ADDR_PC;
      src_a_c     = SRCA_REG;
      src_b_c     = SRCB_REG;
      res_src_c   = RES_ALU_OUT;
      alu_ctl_c   = ALU_ADD;
      case (state_reg)
         S_FETCH: begin
            src_a_c    = SRCA_PC;
            src_b_c    = SRCB_FOUR;
            res_src_c  = RES_ALU_RESULT;
            ir_write_c = bus.memory_ready && reset_n;
            pc_write_c = bus.memory_ready && reset_n;
            state_next = bus.memory_ready ? S_DECODE : S_FETCH;
         end
         S_DECODE: begin
            src_a_c   = SRCA_PC;
            src_b_c   = SRCB_FOUR;
            res_src_c = RES_ALU_RESULT;
            case (bus.operation)
               OP_MEM:  state_next = S_MEM_ADDRESS;
               OP_DP:   state_next = bus.function_field[5] ? S_EXECUTE_IMM : S_EXECUTE_REG;
               OP_BR:   state_next = S_BRANCH;
               default: state_next = S_FETCH;
            endcase
         end
         S_MEM_ADDRESS: begin
            src_b_c    = SRCB_IMM;
            state_next = bus.function_field[0] ? S_MEM_READ : S_MEM_WRITE;
         end
         S_MEM_READ: begin
            addr_src_c = ADDR_RESULT;
            state_next = bus.memory_ready ? S_MEM_WRITEBACK : S_MEM_READ;
         end
         S_MEM_WRITEBACK: begin
            res_src_c   = RES_READ_DATA;
            reg_write_c = wr_ok;
            pc_write_c  = wr_ok && (bus.destination == 4'hF);
         end
         S_MEM_WRITE: begin
            addr_src_c  = ADDR_RESULT;
            mem_write_c = wr_ok;
            state_next  = bus.memory_ready ? S_FETCH : S_MEM_WRITE;
         end
         S_EXECUTE_REG: begin
            alu_ctl_c  = dp.ctl;
            state_next = S_ALU_WRITEBACK;
         end
         S_EXECUTE_IMM: begin
            src_b_c    = SRCB_IMM;
            alu_ctl_c  = dp.ctl;
            state_next = S_ALU_WRITEBACK;
         end
         S_ALU_WRITEBACK: begin
            reg_write_c = wr_ok && dp.valid;
            pc_write_c  = wr_ok && dp.valid && (bus.destination == 4'hF);
         end
         S_BRANCH: begin
            src_b_c    = SRCB_IMM;
            res_src_c  = RES_ALU_RESULT;
            pc_write_c = wr_ok;
         end
         default: state_next = S_FETCH;
      endcase
   end

   // Immediate and register-port selects decode the held instruction so they
   // are already valid while DECODE reads the register file.
   always_comb begin
      case (bus.operation)
         OP_MEM:  bus.immediate_source = IMM_MEM;
         OP_BR:   bus.immediate_source = IMM_BR;
         default: bus.immediate_source = IMM_DP;
      endcase
   end

   assign bus.register_source = {(bus.operation == OP_MEM) && !bus.function_field[0],
                                 bus.operation == OP_BR};

   assign bus.pc_write                   = pc_write_c;
   assign bus.instruction_register_write = ir_write_c;
   assign bus.register_write             = reg_write_c;
   assign bus.memory_write               = mem_write_c;
   assign bus.address_source             = addr_src_c;
   assign bus.alu_source_a               = src_a_c;
   assign bus.alu_source_b               = src_b_c;
   assign bus.result_source              = res_src_c;
   assign bus.alu_control                = alu_ctl_c;
   assign bus.state                      = state_reg;

endmodule
